// File: rtl/mul_seq_if.sv
// Start/busy handshake and product bus shared by the HI/LO controller and the multiplier.
interface mul_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             sign;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;

    // Requester side (EX-stage HI/LO controller).
    modport master (
        output start, sign, a, b,
        input  hi, lo, busy, done
    );

    // Multiplier side.
    modport slave (
        input  start, sign, a, b,
        output hi, lo, busy, done
    );
endinterface

// File: rtl/mul_seq.sv
// Sequential radix-2 shift-add multiplier for MULT/MULTU; one product bit per falling edge.
module mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic      clock,
    input  logic      resetn,
    mul_seq_if.slave  bus
);
    localparam int unsigned W  = WIDTH;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W:0]      acc_q, acc_d;
    logic [W-1:0]    mq_q, mq_d;
    logic [W-1:0]    ma_q, ma_d;
    logic [CW-1:0]   count_q, count_d;
    logic            neg_q, neg_d;
    logic [W-1:0]    hi_q, hi_d;
    logic [W-1:0]    lo_q, lo_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [W-1:0]    abs_a, abs_b;
    logic [W:0]      sum;
    logic [2*W-1:0]  prod_p, prod_n;

    // Operand magnitudes, partial-product sum and final sign fix-up.
    always_comb begin
        abs_a  = (bus.sign && bus.a[W-1]) ? W'(~bus.a + W'(1)) : bus.a;
        abs_b  = (bus.sign && bus.b[W-1]) ? W'(~bus.b + W'(1)) : bus.b;
        sum    = (W+1)'(acc_q + {1'b0, (mq_q[0] ? ma_q : W'(0))});
        prod_p = {acc_q[W-1:0], mq_q};
        prod_n = (2*W)'(~prod_p + (2*W)'(1));
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        ma_d    = ma_q;
        count_d = count_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    ma_d    = abs_a;
                    mq_d    = abs_b;
                    neg_d   = bus.sign & (bus.a[W-1] ^ bus.b[W-1]);
                    acc_d   = '0;
                    count_d = '0;
                    busy_d  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_d   = {1'b0, sum[W:1]};
                mq_d    = {sum[0], mq_q[W-1:1]};
                count_d = CW'(count_q + CW'(1));
                if (count_q == CW'(W-1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                {hi_d, lo_d} = neg_q ? prod_n : prod_p;
                busy_d       = 1'b0;
                done_d       = 1'b1;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; updates on the falling edge like the divider, reset discards any partial run.
    always_ff @(negedge clock) begin
        if (resetn) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            mq_q    <= '0;
            ma_q    <= '0;
            count_q <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            ma_q    <= ma_d;
            count_q <= count_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: driver pushes expected products, monitor checks them on done.
module tb_mul_seq;
    localparam int unsigned W = 32;

    logic clock = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   errors   = 0;
    int   edge_cnt = 0;

    typedef struct {
        logic [63:0] prod;
        int          edge_n;
    } exp_t;

    exp_t sb_q[$];

    always #5 clock = ~clock;

    mul_seq_if #(.WIDTH(W)) bus ();

    mul_seq #(.WIDTH(W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Falling edges are the DUT's active edges; count them for latency checks.
    always @(negedge clock) edge_cnt <= edge_cnt + 1;

    function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a, input logic [31:0] b);
        if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
        return 64'(a) * 64'(b);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(posedge clock) begin
        exp_t e;
        if (resetn === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                e = sb_q.pop_front();
                check("hi", 64'(bus.hi), 64'(e.prod[63:32]));
                check("lo", 64'(bus.lo), 64'(e.prod[31:0]));
                check("latency", 64'(edge_cnt), 64'(e.edge_n + int'(W) + 1));
                check("busy_at_done", 64'(bus.busy), 64'(0));
            end
        end
    end

    // Called at a rising edge: present a start for one falling edge, optionally expecting a result.
    task automatic drive(input bit s, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [63:0] exp);
        exp_t e;
        bus.start = 1'b1;
        bus.sign  = s;
        bus.a     = a;
        bus.b     = b;
        @(negedge clock);
        #1;
        if (push) begin
            e.prod   = exp;
            e.edge_n = edge_cnt;
            sb_q.push_back(e);
        end
        @(posedge clock);
        bus.start = 1'b0;
    endtask

    task automatic issue_exp(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
        @(posedge clock);
        drive(s, a, b, 1'b1, exp);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(posedge clock);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
            sb_q.delete();
        end
    endtask

    // Returns at the rising edge where done is seen.
    task automatic wait_done_edge();
        int n = 0;
        do begin
            @(posedge clock);
            n++;
        end while (bus.done !== 1'b1 && n < 200);
        if (bus.done !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL done_edge_timeout: got done=%b expected 1", bus.done);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          bc;
        bit          s;
        logic [31:0] a, b;
        logic [31:0] corners[6];

        corners[0] = 32'h0000_0000;
        corners[1] = 32'h0000_0001;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h8000_0001;

        resetn    = 1'b1;
        bus.start = 1'b0;
        bus.sign  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clock);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_hilo", {bus.hi, bus.lo}, 64'(0));
        resetn = 1'b0;

        // Largest unsigned product and busy width.
        issue_exp(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        bc = 0;
        while (bus.busy === 1'b1 && bc < 200) begin
            bc++;
            @(posedge clock);
        end
        check("busy_len", 64'(bc), 64'(33));
        wait_done();

        // Sign handling.
        issue_exp(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
        wait_done();
        issue_exp(1'b0, 32'hFFFF_FFFD, 32'h0000_0007, 64'h0000_0006_FFFF_FFEB);
        wait_done();
        issue_exp(1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        wait_done();
        issue_exp(1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000);
        wait_done();

        // Start while busy is ignored; start in the done cycle is accepted.
        issue_exp(1'b0, 32'd5, 32'd6, 64'h1E);
        repeat (9) @(posedge clock);
        drive(1'b0, 32'd9, 32'd9, 1'b0, 64'h0);
        wait_done_edge();
        drive(1'b1, 32'hFFFF_FFFC, 32'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);
        wait_done();

        // Reset mid-run discards the operation and clears the outputs.
        issue_exp(1'b0, 32'h0001_2345, 32'h0000_0777, 64'h0);
        repeat (11) @(posedge clock);
        resetn = 1'b1;
        @(posedge clock);
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_done", 64'(bus.done), 64'(0));
        check("midrst_hilo", {bus.hi, bus.lo}, 64'(0));
        sb_q.delete();
        resetn = 1'b0;
        issue_exp(1'b0, 32'd7, 32'd8, 64'h38);
        wait_done();

        // Zero operands, including signed cases where the sign flag is set.
        issue_exp(1'b0, 32'h0, 32'h1234_5678, 64'h0);
        wait_done();
        issue_exp(1'b0, 32'hDEAD_BEEF, 32'h0, 64'h0);
        wait_done();
        issue_exp(1'b1, 32'h0, 32'hFFFF_FFFF, 64'h0);
        wait_done();
        issue_exp(1'b1, 32'h8000_0000, 32'h0, 64'h0);
        wait_done();

        // Random vectors against the 64-bit arithmetic reference.
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
            b = ($urandom_range(0, 7) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 3) == 0 && i > 0) begin
                issue_exp(s, a, b, ref_mul(s, a, b));
                wait_done_edge();
                s = ~s;
                drive(s, b, a, 1'b1, ref_mul(s, b, a));
            end else begin
                issue_exp(s, a, b, ref_mul(s, a, b));
            end
            wait_done();
        end

        repeat (3) @(posedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
